display_scan_controller: RTL

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one hex-to-segment decoder. It holds a multi-digit hex value, presents one nibble at a time to the shared decoder, and drives the active-low digit anodes with a blanking gap between digits to prevent ghosting. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/display_scan_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for common-anode seven-segment digits sharing one decoder.
// The displayed value is double-buffered and swapped only at frame boundaries (or while idle).
module display_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          enable,
    input  logic                                          load,
    input  logic [4*DIGITS-1:0]                           value,
    output logic [3:0]                                    nibble,
    output logic [DIGITS-1:0]                             anode,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digitIdx,
    output logic                                          frameDone,
    output logic                                          pending
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_C = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] w_shadow_nxt;
    logic [4*DIGITS-1:0] r_active;
    logic [4*DIGITS-1:0] w_active_nxt;
    logic                r_pending;
    logic                w_pending_nxt;
    logic [3:0]          r_nibble;
    logic [3:0]          w_nibble_nxt;
    logic [DIGITS-1:0]   r_anode;
    logic [DIGITS-1:0]   w_anode_nxt;
    logic [DIGITS-1:0]   w_sig;
    logic                r_frame_done;
    logic                w_frame_done_nxt;
    logic                w_boundary;
    logic                w_commit;

    function automatic logic [3:0] digit_sel(input logic [4*DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]    idx);
        logic [4*DIGITS-1:0] shifted;
        shifted = v >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    // Bit i set when digit i or any more-significant digit is non-zero; digit 0 always set.
    function automatic logic [DIGITS-1:0] significant(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] sig;
        logic              seen;
        seen = 1'b0;
        sig  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen   = seen | (v[4*i +: 4] != 4'h0);
            sig[i] = seen;
        end
        sig[0] = 1'b1;
        return sig;
    endfunction

    // Double buffer: a load coinciding with a commit goes straight to the active value.
    always_comb begin
        w_boundary    = enable && (r_state == S_SHOW) && (r_cnt == '0) && (r_idx == LAST_IDX);
        w_commit      = ((r_state == S_IDLE) && r_pending) || w_boundary;
        w_shadow_nxt  = load ? value : r_shadow;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        if (w_commit) begin
            w_active_nxt  = load ? value : r_shadow;
            w_pending_nxt = 1'b0;
        end else if (load) begin
            w_pending_nxt = 1'b1;
        end
    end

    // The counter is reloaded on every state entry and counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = BLANK_LOAD;
                    w_idx_nxt   = '0;
                end
                S_BLANK: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_SHOW;
                        w_cnt_nxt   = SHOW_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_BLANK;
                        w_cnt_nxt   = BLANK_LOAD;
                        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : (r_idx + IDX_ONE);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from next-state values so they register together with the state.
    always_comb begin
        w_sig        = significant(w_active_nxt);
        w_nibble_nxt = digit_sel(w_active_nxt, w_idx_nxt);
        w_anode_nxt  = '1;
        if ((w_state_nxt == S_SHOW) && ((LZ_SUPPRESS == 0) || w_sig[w_idx_nxt])) begin
            w_anode_nxt[w_idx_nxt] = 1'b0;
        end
        w_frame_done_nxt = (w_state_nxt == S_SHOW) && (w_cnt_nxt == '0) && (w_idx_nxt == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_nibble     <= 4'h0;
            r_anode      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_nibble     <= w_nibble_nxt;
            r_anode      <= w_anode_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign nibble    = r_nibble;
    assign anode     = r_anode;
    assign digitIdx  = r_idx;
    assign frameDone = r_frame_done;
    assign pending   = r_pending;

endmodule
